glyph_bitmap_renderer: RTL and testbench

GLYPH_BITMAP_RENDERER -- requirements
Module: glyph_bitmap_renderer

---
 rtl/glyph_bitmap_renderer.sv | 130 +++++++++++++
 tb/tb_glyph_bitmap_renderer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/glyph_bitmap_renderer.sv
// glyph_bitmap_renderer: maps the scan position onto a scaled 1-bpp bitmap window,
// issues the RAM read address, and emits the selected pixel with the video timing
// signals delayed to match the three-clock read pipeline.
module glyph_bitmap_renderer #(
    parameter int ADDR_WIDTH    = 9,
    parameter int DATA_WIDTH    = 8,
    parameter int COORD_WIDTH   = 10,
    parameter int ORIGIN_X      = 64,
    parameter int ORIGIN_Y      = 32,
    parameter int WORDS_PER_ROW = 4,
    parameter int ROWS          = 128,
    parameter int SCALE_LOG2    = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [COORD_WIDTH-1:0] i_x,
    input  logic [COORD_WIDTH-1:0] i_y,
    input  logic                   i_active,
    input  logic                   i_hsync,
    input  logic                   i_vsync,
    output logic [ADDR_WIDTH-1:0]  o_addr,
    input  logic [DATA_WIDTH-1:0]  i_ram_dout,
    output logic                   o_pixel,
    output logic                   o_in_window,
    output logic                   o_active,
    output logic                   o_hsync,
    output logic                   o_vsync
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int WIN_W = (WORDS_PER_ROW * DATA_WIDTH) << SCALE_LOG2;
    localparam int WIN_H = ROWS << SCALE_LOG2;

    localparam logic [31:0] X_LO = 32'(ORIGIN_X);
    localparam logic [31:0] X_HI = 32'(ORIGIN_X + WIN_W);
    localparam logic [31:0] Y_LO = 32'(ORIGIN_Y);
    localparam logic [31:0] Y_HI = 32'(ORIGIN_Y + WIN_H);

    // Window test is done at 32 bits so positions left of / above the origin never wrap inside.
    logic [31:0]            w_x32;
    logic [31:0]            w_y32;
    logic                   w_in_window;
    logic [COORD_WIDTH-1:0] w_dx;
    logic [COORD_WIDTH-1:0] w_dy;
    logic [BIT_W-1:0]       w_bit;

    assign w_x32 = 32'(i_x);
    assign w_y32 = 32'(i_y);
    assign w_in_window = i_active
                       & (w_x32 >= X_LO) & (w_x32 < X_HI)
                       & (w_y32 >= Y_LO) & (w_y32 < Y_HI);

    // Offsets are only meaningful inside the window, where they cannot underflow.
    assign w_dx = (i_x - COORD_WIDTH'(ORIGIN_X)) >> SCALE_LOG2;
    assign w_dy = (i_y - COORD_WIDTH'(ORIGIN_Y)) >> SCALE_LOG2;

    // DATA_WIDTH is a power of two, so DATA_WIDTH-1-(dx mod DATA_WIDTH) is the bitwise
    // complement of the low dx bits: word MSB is the leftmost pixel.
    assign w_bit = ~w_dx[BIT_W-1:0];

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BIT_W-1:0]      r_bit_p1, r_bit_p2;
    logic                  r_win_p1, r_win_p2;
    logic                  r_act_p1, r_act_p2;
    logic                  r_hs_p1,  r_hs_p2;
    logic                  r_vs_p1,  r_vs_p2;
    logic                  r_pixel, r_win, r_act, r_hs, r_vs;

    // Stage 1: address (held outside the window) plus bit index and timing flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr   <= '0;
            r_bit_p1 <= '0;
            r_win_p1 <= 1'b0;
            r_act_p1 <= 1'b0;
            r_hs_p1  <= 1'b1;
            r_vs_p1  <= 1'b1;
        end else begin
            if (w_in_window)
                r_addr <= ADDR_WIDTH'(32'(w_dy) * 32'(WORDS_PER_ROW) + 32'(w_dx >> BIT_W));
            r_bit_p1 <= w_bit;
            r_win_p1 <= w_in_window;
            r_act_p1 <= i_active;
            r_hs_p1  <= i_hsync;
            r_vs_p1  <= i_vsync;
        end
    end

    // Stage 2: carry bit index and flags while the RAM read is in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_p2 <= '0;
            r_win_p2 <= 1'b0;
            r_act_p2 <= 1'b0;
            r_hs_p2  <= 1'b1;
            r_vs_p2  <= 1'b1;
        end else begin
            r_bit_p2 <= r_bit_p1;
            r_win_p2 <= r_win_p1;
            r_act_p2 <= r_act_p1;
            r_hs_p2  <= r_hs_p1;
            r_vs_p2  <= r_vs_p1;
        end
    end

    // Stage 3: pick the pixel from returned RAM data, gated by the aligned window flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pixel <= 1'b0;
            r_win   <= 1'b0;
            r_act   <= 1'b0;
            r_hs    <= 1'b1;
            r_vs    <= 1'b1;
        end else begin
            r_pixel <= r_win_p2 & i_ram_dout[r_bit_p2];
            r_win   <= r_win_p2;
            r_act   <= r_act_p2;
            r_hs    <= r_hs_p2;
            r_vs    <= r_vs_p2;
        end
    end

    assign o_addr      = r_addr;
    assign o_pixel     = r_pixel;
    assign o_in_window = r_win;
    assign o_active    = r_act;
    assign o_hsync     = r_hs;
    assign o_vsync     = r_vs;

endmodule

// File: tb/tb_glyph_bitmap_renderer.sv
// Directed bench for glyph_bitmap_renderer with a synchronous-read bitmap RAM model.
module tb_glyph_bitmap_renderer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] x, y;
    logic       act, hs, vs;
    logic [8:0] addr;
    logic [7:0] ram_dout;
    logic       pixel, in_win, o_act, o_hs, o_vs;

    logic [7:0] ram [0:511];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Block RAM model: data valid one clock after the address is presented.
    always @(posedge clk) ram_dout <= ram[addr];

    glyph_bitmap_renderer dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_x         (x),
        .i_y         (y),
        .i_active    (act),
        .i_hsync     (hs),
        .i_vsync     (vs),
        .o_addr      (addr),
        .i_ram_dout  (ram_dout),
        .o_pixel     (pixel),
        .o_in_window (in_win),
        .o_active    (o_act),
        .o_hsync     (o_hs),
        .o_vsync     (o_vs)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one pixel, clock it in, then settle just after the edge.
    task automatic step(input int sx, input int sy, input logic sa, input logic sh, input logic sv);
        x   = 10'(sx);
        y   = 10'(sy);
        act = sa;
        hs  = sh;
        vs  = sv;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"},  32'(addr),   32'd0);
        chk({tag, "_pix"},   32'(pixel),  32'd0);
        chk({tag, "_win"},   32'(in_win), 32'd0);
        chk({tag, "_act"},   32'(o_act),  32'd0);
        chk({tag, "_hs"},    32'(o_hs),   32'd1);
        chk({tag, "_vs"},    32'(o_vs),   32'd1);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 8'h00;
        ram[0] = 8'h80;
        ram[4] = 8'h01;
        ram[5] = 8'h80;
        rst_n = 1'b0;
        x = '0; y = '0; act = 1'b0; hs = 1'b1; vs = 1'b1;

        // Reset held with random in-window-ish inputs.
        for (int i = 0; i < 4; i++)
            step(64 + int'($urandom_range(0, 63)), 32 + int'($urandom_range(0, 255)),
                 1'($urandom), 1'($urandom), 1'($urandom));
        chk_reset_vals("rst_hold");
        rst_n = 1'b1;
        idle(); idle(); idle();

        // Origin pixel, RAM[0]=80.
        step(64, 32, 1'b1, 1'b1, 1'b1);
        chk("org_addr", 32'(addr), 32'd0);
        idle(); idle();
        chk("org_pix", 32'(pixel), 32'd1);
        chk("org_win", 32'(in_win), 32'd1);
        chk("org_act", 32'(o_act), 32'd1);

        // x=65 still bitmap pixel 0 (scale 2); x=66 is pixel 1.
        step(65, 32, 1'b1, 1'b1, 1'b1);
        idle(); idle();
        chk("x65_pix", 32'(pixel), 32'd1);
        step(66, 32, 1'b1, 1'b1, 1'b1);
        idle(); idle();
        chk("x66_pix", 32'(pixel), 32'd0);

        // Word boundary: x=79 -> addr 4 bit 0; x=80 -> addr 5 bit 7.
        step(79, 34, 1'b1, 1'b1, 1'b1);
        chk("x79_addr", 32'(addr), 32'd4);
        idle(); idle();
        chk("x79_pix", 32'(pixel), 32'd1);
        step(80, 34, 1'b1, 1'b1, 1'b1);
        chk("x80_addr", 32'(addr), 32'd5);
        idle(); idle();
        chk("x80_pix", 32'(pixel), 32'd1);

        // Window edges with RAM all ones.
        for (int i = 0; i < 512; i++) ram[i] = 8'hFF;
        step(127, 287, 1'b1, 1'b1, 1'b1);
        chk("br_addr", 32'(addr), 32'd511);
        idle(); idle();
        chk("br_win", 32'(in_win), 32'd1);
        chk("br_pix", 32'(pixel), 32'd1);

        step(128, 287, 1'b1, 1'b1, 1'b1);
        chk("x128_addr", 32'(addr), 32'd511);
        idle(); idle();
        chk("x128_win", 32'(in_win), 32'd0);
        chk("x128_pix", 32'(pixel), 32'd0);
        chk("x128_act", 32'(o_act), 32'd1);

        step(63, 100, 1'b1, 1'b1, 1'b1);
        chk("x63_addr", 32'(addr), 32'd511);
        idle(); idle();
        chk("x63_win", 32'(in_win), 32'd0);
        chk("x63_pix", 32'(pixel), 32'd0);

        step(100, 288, 1'b1, 1'b1, 1'b1);
        chk("y288_addr", 32'(addr), 32'd511);
        idle(); idle();
        chk("y288_win", 32'(in_win), 32'd0);
        chk("y288_pix", 32'(pixel), 32'd0);

        // Sync pulses: hsync low on step 1, vsync low on step 2; outputs lag 3 edges.
        for (int k = 0; k < 7; k++) begin
            step(0, 0, 1'b0, (k == 1) ? 1'b0 : 1'b1, (k == 2) ? 1'b0 : 1'b1);
            chk($sformatf("hs_k%0d", k), 32'(o_hs), (k == 3) ? 32'd0 : 32'd1);
            chk($sformatf("vs_k%0d", k), 32'(o_vs), (k == 4) ? 32'd0 : 32'd1);
            chk($sformatf("sync_pix_k%0d", k), 32'(pixel), 32'd0);
        end

        // Reset during a streamed in-window run (x=70,y=40 -> addr 16).
        for (int k = 0; k < 4; k++) step(70, 40, 1'b1, 1'b1, 1'b1);
        chk("pre_rst_addr", 32'(addr), 32'd16);
        chk("pre_rst_pix", 32'(pixel), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        step(70, 40, 1'b1, 1'b1, 1'b1);
        chk_reset_vals("rst_mid_clk");
        rst_n = 1'b1;
        step(70, 40, 1'b1, 1'b1, 1'b1);
        chk("rel1_addr", 32'(addr), 32'd16);
        chk("rel1_win", 32'(in_win), 32'd0);
        step(70, 40, 1'b1, 1'b1, 1'b1);
        chk("rel2_win", 32'(in_win), 32'd0);
        chk("rel2_pix", 32'(pixel), 32'd0);
        step(70, 40, 1'b1, 1'b1, 1'b1);
        chk("rel3_win", 32'(in_win), 32'd1);
        chk("rel3_pix", 32'(pixel), 32'd1);
        chk("rel3_act", 32'(o_act), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
